// File: rtl/uart_tx_if.sv
// UART transmitter host-side bundle.
// Host drives the request, the transmitter drives the line and busy flag.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;

    modport master (
        output tx_start,
        output tx_data,
        input  tx,
        input  tx_busy
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop.
// Bit timing from an internal baud counter; all outputs registered.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    localparam logic [15:0] CNT_MAX   = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic        HAS_PAR   = (PARITY != 0);
    localparam logic        ODD_PAR   = (PARITY == 2);

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic        stop_cnt;
    logic        tx_q;
    logic        busy_q;
    logic        par_bit;

    assign par_bit    = (^shreg) ^ ODD_PAR;
    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;

    // Frame sequencer: advances one serial bit per baud terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            stop_cnt <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else if (state == S_IDLE) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            cnt    <= '0;
            if (bus.tx_start) begin
                shreg  <= bus.tx_data;
                tx_q   <= 1'b0;
                busy_q <= 1'b1;
                state  <= S_START;
            end
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 16'd1;
        end else begin
            cnt <= '0;
            unique case (state)
                S_START: begin
                    state <= S_DATA;
                    idx   <= '0;
                    tx_q  <= shreg[0];
                end
                S_DATA: begin
                    if (idx == 3'd7) begin
                        if (HAS_PAR) begin
                            state <= S_PAR;
                            tx_q  <= par_bit;
                        end else begin
                            state    <= S_STOP;
                            stop_cnt <= 1'b0;
                            tx_q     <= 1'b1;
                        end
                    end else begin
                        idx  <= idx + 3'd1;
                        tx_q <= shreg[idx + 3'd1];
                    end
                end
                S_PAR: begin
                    state    <= S_STOP;
                    stop_cnt <= 1'b0;
                    tx_q     <= 1'b1;
                end
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (stop_cnt == STOP_LAST) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three parameterisations, frame scoreboard on the line.
// Expected frames are queued at request time and checked cycle by cycle.
module tb_uart_tx;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_if if0 ();
    uart_tx_if if1 ();
    uart_tx_if if2 ();

    uart_tx #(.CLKS_PER_BIT(CPB)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          len;
        int          gap;
    } exp_t;

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         par;
        logic       pb;
        int         nstop;
        int         len;
    } vec_t;

    exp_t q[$];
    exp_t cur;

    int n_cmp = 0;
    int n_bad = 0;
    int sel = 0;

    logic mtx;
    logic mbusy;

    always_comb begin
        mtx   = if0.tx;
        mbusy = if0.tx_busy;
        case (sel)
            1: begin mtx = if1.tx; mbusy = if1.tx_busy; end
            2: begin mtx = if2.tx; mbusy = if2.tx_busy; end
            default: ;
        endcase
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(logic [7:0] d, int par, logic pb,
                                int nstop, int len, int gap);
        exp_t e;
        e.bits = '1;
        e.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) e.bits[1 + i] = d[i];
        e.nbits = 9;
        if (par != 0) begin
            e.bits[9] = pb;
            e.nbits = 10;
        end
        for (int i = 0; i < nstop; i++) begin
            e.bits[e.nbits] = 1'b1;
            e.nbits++;
        end
        e.len = len;
        e.gap = gap;
        return e;
    endfunction

    // Line monitor: pops one expected frame per busy rising edge.
    int   k = 0;
    int   idle_cnt = 0;
    bit   in_frame = 0;
    bit   bad = 0;
    logic badv;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 0;
            k = 0;
            idle_cnt = 0;
        end else if (mbusy) begin
            if (!in_frame) begin
                if (q.size() == 0) begin
                    chk("spurious_frame", 32'(mbusy), 32'd0);
                    cur.nbits = 0;
                    cur.len = -1;
                    cur.gap = -1;
                end else begin
                    cur = q.pop_front();
                    if (cur.gap >= 0) chk("gap", idle_cnt, cur.gap);
                end
                in_frame = 1;
                k = 0;
                bad = 0;
            end
            if (k / CPB < cur.nbits) begin
                if (mtx !== cur.bits[k / CPB] && !bad) begin
                    bad = 1;
                    badv = mtx;
                end
                if (k % CPB == CPB - 1) begin
                    chk($sformatf("bit%0d", k / CPB),
                        32'(bad ? badv : mtx), 32'(cur.bits[k / CPB]));
                    bad = 0;
                end
            end
            k++;
            idle_cnt = 0;
        end else begin
            if (in_frame) begin
                if (cur.len >= 0) chk("busy_len", k, cur.len);
                chk("end_tx", 32'(mtx), 32'd1);
                in_frame = 0;
            end
            idle_cnt++;
        end
    end

    task automatic drive(int s, logic st, logic [7:0] d);
        case (s)
            1: begin if1.tx_start = st; if1.tx_data = d; end
            2: begin if2.tx_start = st; if2.tx_data = d; end
            default: begin if0.tx_start = st; if0.tx_data = d; end
        endcase
    endtask

    task automatic send(int s, logic [7:0] d);
        @(negedge clk);
        drive(s, 1'b1, d);
        @(negedge clk);
        drive(s, 1'b0, 8'($urandom));
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while ((in_frame || q.size() != 0 || mbusy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done: timeout after %0d cycles, queue %0d",
                     n, q.size());
            q.delete();
        end
    endtask

    task automatic wait_busy(logic lvl, int budget, string nm);
        int n = 0;
        while (mbusy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: busy stuck at %b, wanted %b", nm, mbusy, lvl);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t vt[8];

    initial begin
        int rbad[3];
        int extra;

        vt[0] = '{0, 8'h5E, 0, 1'b0, 1, 160};
        vt[1] = '{1, 8'h5E, 1, 1'b1, 2, 192};
        vt[2] = '{2, 8'h5E, 2, 1'b0, 1, 176};
        vt[3] = '{0, 8'h00, 0, 1'b0, 1, 160};
        vt[4] = '{0, 8'hFF, 0, 1'b0, 1, 160};
        vt[5] = '{1, 8'hA5, 1, 1'b0, 2, 192};
        vt[6] = '{2, 8'h3C, 2, 1'b1, 1, 176};
        vt[7] = '{1, 8'h01, 1, 1'b1, 2, 192};

        for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'h00);
        rbad = '{0, 0, 0};

        // Reset held 50 cycles with a request pulsed in the middle.
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (if0.tx !== 1'b1 || if0.tx_busy !== 1'b0) rbad[0]++;
            if (if1.tx !== 1'b1 || if1.tx_busy !== 1'b0) rbad[1]++;
            if (if2.tx !== 1'b1 || if2.tx_busy !== 1'b0) rbad[2]++;
            for (int s = 0; s < 3; s++)
                drive(s, (c == 10), 8'hC3);
        end
        chk("reset_u0_bad_cycles", rbad[0], 0);
        chk("reset_u1_bad_cycles", rbad[1], 0);
        chk("reset_u2_bad_cycles", rbad[2], 0);

        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("idle_u0", {if0.tx, if0.tx_busy}, 2'b10);
        chk("idle_u1", {if1.tx, if1.tx_busy}, 2'b10);
        chk("idle_u2", {if2.tx, if2.tx_busy}, 2'b10);

        // Table-driven single frames across the three parameter sets.
        for (int i = 0; i < 8; i++) begin
            sel = vt[i].sel;
            q.push_back(mk(vt[i].data, vt[i].par, vt[i].pb,
                           vt[i].nstop, vt[i].len, -1));
            send(vt[i].sel, vt[i].data);
            wait_done(400);
            repeat (3) @(negedge clk);
        end

        // Request while busy must be ignored.
        sel = 0;
        q.push_back(mk(8'h5E, 0, 1'b0, 1, 160, -1));
        send(0, 8'h5E);
        repeat (40) @(negedge clk);
        drive(0, 1'b1, 8'hFF);
        @(negedge clk);
        drive(0, 1'b0, 8'hFF);
        wait_done(400);
        extra = 0;
        repeat (200) begin
            @(negedge clk);
            if (mbusy) extra++;
        end
        chk("reject_no_second_frame", extra, 0);

        // tx_start held high: two frames, one idle cycle apart.
        q.push_back(mk(8'hA5, 0, 1'b0, 1, 160, -1));
        q.push_back(mk(8'h3C, 0, 1'b0, 1, 160, 1));
        @(negedge clk);
        drive(0, 1'b1, 8'hA5);
        @(negedge clk);
        drive(0, 1'b1, 8'h3C);
        wait_busy(1'b0, 400, "b2b_first_end");
        wait_busy(1'b1, 10, "b2b_second_start");
        drive(0, 1'b0, 8'h00);
        wait_done(400);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (mbusy) extra++;
        end
        chk("b2b_no_third_frame", extra, 0);

        // Asynchronous reset during data bit 3, then a clean frame.
        q.push_back(mk(8'h5E, 0, 1'b0, 1, 160, -1));
        send(0, 8'h5E);
        repeat (70) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx", 32'(if0.tx), 32'd1);
        chk("midrst_busy", 32'(if0.tx_busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        q.push_back(mk(8'h5E, 0, 1'b0, 1, 160, -1));
        send(0, 8'h5E);
        wait_done(400);

        @(negedge clk);
        chk("final_idle", {if0.tx, if0.tx_busy}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
